// File: rtl/sound_pkg.sv
// sound_pkg: shared width helpers and channel state encoding for sound_poly.
package sound_pkg;

    // Index width that stays at least 1 bit wide even for a single entry.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int pwm_w(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } ch_state_e;

endpackage

// File: rtl/sound_channel.sv
// sound_channel: one tone voice with a half-period divider, square phase and optional tick-based duration.
module sound_channel
    import sound_pkg::*;
#(
    parameter int DIV_W = 20,
    parameter int DUR_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [DUR_W-1:0] dur_i,
    input  logic             tick_i,
    output logic             active_o,
    output logic             phase_o,
    output logic             done_o
);

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             phase_q, phase_d;
    logic             done_q, done_d;
    logic             expire;

    assign expire = (state_q == ST_PLAY) && tick_i && (dur_q == DUR_W'(1));

    // A write on the expiry cycle takes priority, so the note restarts with no done pulse.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        dur_d   = dur_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        if (load_i) begin
            state_d = (div_i == '0) ? ST_IDLE : ST_PLAY;
            div_d   = div_i;
            half_d  = div_i - 1'b1;
            dur_d   = dur_i;
            phase_d = 1'b0;
        end else if (state_q == ST_PLAY) begin
            if (expire) begin
                state_d = ST_IDLE;
                phase_d = 1'b0;
                done_d  = 1'b1;
            end else begin
                half_d  = (half_q == '0) ? div_q - 1'b1 : half_q - 1'b1;
                phase_d = (half_q == '0) ? ~phase_q : phase_q;
                dur_d   = (tick_i && dur_q != '0) ? dur_q - 1'b1 : dur_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            half_q  <= '0;
            dur_q   <= '0;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            dur_q   <= dur_d;
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

    assign active_o = (state_q == ST_PLAY);
    assign phase_o  = phase_q;
    assign done_o   = done_q;

endmodule

// File: rtl/sound_poly.sv
// sound_poly: CH-channel square-wave tone generator mixed into a 1-bit PWM speaker output.
module sound_poly
    import sound_pkg::*;
#(
    parameter int  CH       = 4,
    parameter int  DIV_W    = 20,
    parameter int  DUR_W    = 16,
    parameter int  TICK_DIV = 50000,
    localparam int CH_W     = idx_w(CH),
    localparam int PWM_W    = pwm_w(CH)
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iWE,
    input  logic [CH_W-1:0]  iCH,
    input  logic [DIV_W-1:0] iDIV,
    input  logic [DUR_W-1:0] iDUR,
    output logic [CH-1:0]    oACTIVE,
    output logic [CH-1:0]    oDONE,
    output logic             oSOUND
);

    localparam int TC_W = idx_w(TICK_DIV);

    logic [TC_W-1:0]  tick_q;
    logic             tick;
    logic             we_ok;
    logic [CH-1:0]    act;
    logic [CH-1:0]    ph;
    logic [CH-1:0]    done;
    logic [PWM_W-1:0] level;
    logic [PWM_W-1:0] pwm_q;
    logic             snd_q;

    // Free-running duration tick shared by every channel; writes never restart it.
    assign tick = (tick_q == TC_W'(TICK_DIV - 1));

    always_ff @(posedge iCLK) begin
        if (iRST || tick) tick_q <= '0;
        else tick_q <= tick_q + 1'b1;
    end

    assign we_ok = iWE && (int'(iCH) < CH);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        sound_channel #(
            .DIV_W(DIV_W),
            .DUR_W(DUR_W)
        ) u_ch (
            .clk_i   (iCLK),
            .rst_i   (iRST),
            .load_i  (we_ok && (iCH == CH_W'(g))),
            .div_i   (iDIV),
            .dur_i   (iDUR),
            .tick_i  (tick),
            .active_o(act[g]),
            .phase_o (ph[g]),
            .done_o  (done[g])
        );
    end

    always_comb begin
        level = '0;
        for (int i = 0; i < CH; i++) level = level + PWM_W'(act[i] & ph[i]);
    end

    // Level-to-duty PWM: high for `level` of every CH clocks.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pwm_q <= '0;
            snd_q <= 1'b0;
        end else begin
            pwm_q <= (pwm_q == PWM_W'(CH - 1)) ? '0 : pwm_q + 1'b1;
            snd_q <= (pwm_q < level);
        end
    end

    assign oACTIVE = act;
    assign oDONE   = done;
    assign oSOUND  = snd_q;

endmodule
